// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the receive FCS checker and the TX generator.
package eth_pkg;

  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_e;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/eth_rx_fcs_check_if.sv
// GMII receive inputs plus the stripped payload stream and end-of-frame status.
interface eth_rx_fcs_check_if;

  logic [7:0] rx_data;
  logic       rx_dv;
  logic       rx_er;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_err;
  logic       stat_ok;
  logic       stat_crc_err;
  logic       stat_runt;
  logic       stat_gmii_err;
  logic       stat_oversize;

  modport slave (
    input  rx_data, rx_dv, rx_er,
    output m_data, m_valid, m_last, m_err,
    output stat_ok, stat_crc_err, stat_runt, stat_gmii_err, stat_oversize
  );

  modport master (
    output rx_data, rx_dv, rx_er,
    input  m_data, m_valid, m_last, m_err,
    input  stat_ok, stat_crc_err, stat_runt, stat_gmii_err, stat_oversize
  );

endinterface

// File: rtl/crc32_d8.sv
// One byte step of the reflected Ethernet CRC-32 (LSB-first bit order, no final XOR).
module crc32_d8
  import eth_pkg::*;
#(
  parameter logic [31:0] POLY = eth_pkg::CRC_POLY
) (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REF = reflect32(POLY);

  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h000000, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_REF) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// GMII receive path: strips preamble/SFD, checks the FCS and forwards the payload
// with the trailing 4 FCS bytes removed through a 5-byte delay line.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 1522,
  parameter logic [31:0] CRC_POLY    = eth_pkg::CRC_POLY,
  parameter logic [31:0] CRC_RESIDUE = eth_pkg::CRC_RESIDUE
) (
  input logic               clk,
  input logic               rst,
  eth_rx_fcs_check_if.slave bus
);

  localparam int unsigned      CNT_W     = $clog2(MAX_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_LEN + 1);
  localparam logic [2:0]       FILL_FULL = 3'd5;

  rx_state_e         state_q, state_d;
  logic [31:0]       crc_q, crc_d, crc_next;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [2:0]        fill_q, fill_d;
  logic [4:0][7:0]   dly_q, dly_d;
  logic [7:0]        m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              m_err_q, m_err_d;
  logic              ok_q, ok_d;
  logic              crc_err_q, crc_err_d;
  logic              runt_q, runt_d;
  logic              gmii_err_q, gmii_err_d;
  logic              oversize_q, oversize_d;
  logic              full;
  logic              bad_crc;

  crc32_d8 #(.POLY(CRC_POLY)) u_crc (
    .crc_in  (crc_q),
    .data    (bus.rx_data),
    .crc_out (crc_next)
  );

  assign full    = (fill_q == FILL_FULL);
  assign bad_crc = (crc_q != CRC_RESIDUE);
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    dly_d      = dly_q;
    m_data_d   = dly_q[0];
    m_valid_d  = 1'b0;
    m_last_d   = 1'b0;
    m_err_d    = 1'b0;
    ok_d       = 1'b0;
    crc_err_d  = 1'b0;
    runt_d     = 1'b0;
    gmii_err_d = 1'b0;
    oversize_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_dv) state_d = (bus.rx_data == PREAMBLE_BYTE) ? PREAMBLE : DROP;
      end

      PREAMBLE: begin
        if (!bus.rx_dv) begin
          state_d = IDLE;
        end else if (bus.rx_data == SFD_BYTE) begin
          state_d = DATA;
          crc_d   = '1;
          cnt_d   = '0;
          fill_d  = '0;
        end else if (bus.rx_data != PREAMBLE_BYTE) begin
          state_d = DROP;
        end
      end

      DATA: begin
        if (!bus.rx_dv) begin
          // The five buffered bytes are the last payload byte plus the FCS.
          state_d = IDLE;
          if (full) begin
            m_valid_d = 1'b1;
            m_last_d  = 1'b1;
            m_err_d   = bad_crc;
            ok_d      = !bad_crc;
            crc_err_d = bad_crc;
          end else begin
            runt_d = 1'b1;
          end
        end else if (bus.rx_er || (cnt_inc > CNT_MAX)) begin
          state_d    = DROP;
          cnt_d      = cnt_inc;
          m_valid_d  = full;
          m_last_d   = full;
          m_err_d    = full;
          gmii_err_d = bus.rx_er;
          oversize_d = !bus.rx_er;
        end else begin
          crc_d = crc_next;
          cnt_d = cnt_inc;
          if (full) begin
            m_valid_d = 1'b1;
            dly_d     = {bus.rx_data, dly_q[4:1]};
          end else begin
            fill_d = fill_q + 3'd1;
            for (int unsigned i = 0; i < 5; i++) begin
              if (fill_q == 3'(i)) dly_d[i] = bus.rx_data;
            end
          end
        end
      end

      DROP: begin
        if (!bus.rx_dv) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      crc_q      <= '1;
      cnt_q      <= '0;
      fill_q     <= '0;
      dly_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_err_q    <= 1'b0;
      ok_q       <= 1'b0;
      crc_err_q  <= 1'b0;
      runt_q     <= 1'b0;
      gmii_err_q <= 1'b0;
      oversize_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      dly_q      <= dly_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_err_q    <= m_err_d;
      ok_q       <= ok_d;
      crc_err_q  <= crc_err_d;
      runt_q     <= runt_d;
      gmii_err_q <= gmii_err_d;
      oversize_q <= oversize_d;
    end
  end

  assign bus.m_data        = m_data_q;
  assign bus.m_valid       = m_valid_q;
  assign bus.m_last        = m_last_q;
  assign bus.m_err         = m_err_q;
  assign bus.stat_ok       = ok_q;
  assign bus.stat_crc_err  = crc_err_q;
  assign bus.stat_runt     = runt_q;
  assign bus.stat_gmii_err = gmii_err_q;
  assign bus.stat_oversize = oversize_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: a default-length instance (A) and a
// MAX_LEN=16 instance (B) see the same GMII stimulus.
module tb_eth_rx_fcs_check;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       e;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_dv = 1'b0;
  logic       rx_er = 1'b0;

  int total = 0;
  int bad   = 0;

  beat_t qa[$];
  beat_t qb[$];
  int    sa[5];  // ok, crc_err, runt, gmii_err, oversize
  int    sb[5];

  logic [7:0] good_pl[$];

  eth_rx_fcs_check_if bus_a();
  eth_rx_fcs_check_if bus_b();

  assign bus_a.rx_data = rx_data;
  assign bus_a.rx_dv   = rx_dv;
  assign bus_a.rx_er   = rx_er;
  assign bus_b.rx_data = rx_data;
  assign bus_b.rx_dv   = rx_dv;
  assign bus_b.rx_er   = rx_er;

  eth_rx_fcs_check dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  eth_rx_fcs_check #(.MAX_LEN(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_a.m_valid === 1'b1) qa.push_back({bus_a.m_data, bus_a.m_last, bus_a.m_err});
    if (bus_b.m_valid === 1'b1) qb.push_back({bus_b.m_data, bus_b.m_last, bus_b.m_err});
    if (bus_a.stat_ok === 1'b1)       sa[0]++;
    if (bus_a.stat_crc_err === 1'b1)  sa[1]++;
    if (bus_a.stat_runt === 1'b1)     sa[2]++;
    if (bus_a.stat_gmii_err === 1'b1) sa[3]++;
    if (bus_a.stat_oversize === 1'b1) sa[4]++;
    if (bus_b.stat_ok === 1'b1)       sb[0]++;
    if (bus_b.stat_crc_err === 1'b1)  sb[1]++;
    if (bus_b.stat_runt === 1'b1)     sb[2]++;
    if (bus_b.stat_gmii_err === 1'b1) sb[3]++;
    if (bus_b.stat_oversize === 1'b1) sb[4]++;
  end

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    rx_data = d;
    rx_dv   = dv;
    rx_er   = er;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0);
  endtask

  // Preamble, SFD, payload (rx_er on index er_at, if any), then one dv-low cycle.
  task automatic send_frame(input logic [7:0] pl[$], input int er_at);
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    foreach (pl[i]) drive(pl[i], 1'b1, (i == er_at));
    drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic clear_mon;
    qa.delete();
    qb.delete();
    for (int k = 0; k < 5; k++) begin
      sa[k] = 0;
      sb[k] = 0;
    end
  endtask

  task automatic test_reset;
    logic [15:0] oa, ob;
    rx_dv   = 1'b1;
    rx_data = 8'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    oa = {bus_a.m_data, bus_a.m_valid, bus_a.m_last, bus_a.m_err, bus_a.stat_ok,
          bus_a.stat_crc_err, bus_a.stat_runt, bus_a.stat_gmii_err, bus_a.stat_oversize};
    ob = {bus_b.m_data, bus_b.m_valid, bus_b.m_last, bus_b.m_err, bus_b.stat_ok,
          bus_b.stat_crc_err, bus_b.stat_runt, bus_b.stat_gmii_err, bus_b.stat_oversize};
    total++;
    if (oa !== 16'h0000) begin
      bad++;
      $display("FAIL reset_outputs_a got=%h want=0000", oa);
    end
    total++;
    if (ob !== 16'h0000) begin
      bad++;
      $display("FAIL reset_outputs_b got=%h want=0000", ob);
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    rx_dv = 1'b0;
    clear_mon();
    idle(3);
    total++;
    if (qa.size() != 0 || qb.size() != 0 || sa[0] + sa[1] + sa[2] + sa[3] + sa[4] != 0) begin
      bad++;
      $display("FAIL reset_quiet got beats=%0d/%0d want 0/0", qa.size(), qb.size());
    end
  endtask

  task automatic test_good;
    beat_t exp;
    int    est[5];
    est = '{1, 0, 0, 0, 0};
    clear_mon();
    send_frame(good_pl, -1);
    idle(3);
    total++;
    if (qa.size() != 9) begin
      bad++;
      $display("FAIL good_count got=%0d want=9", qa.size());
    end
    for (int i = 0; i < 9; i++) begin
      exp = {8'(8'h31 + i), (i == 8), 1'b0};
      total++;
      if (i >= qa.size() || qa[i] !== exp) begin
        bad++;
        $display("FAIL good_beat%0d got=%h want=%h", i, (i < qa.size()) ? qa[i] : 10'h3FF, exp);
      end
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (sa[k] !== est[k]) begin
        bad++;
        $display("FAIL good_stat%0d got=%0d want=%0d", k, sa[k], est[k]);
      end
    end
  endtask

  task automatic test_crc_err;
    logic [7:0] pl[$];
    beat_t      exp;
    int         est[5];
    est = '{0, 1, 0, 0, 0};
    pl = good_pl;
    pl[12] = 8'hCA;
    clear_mon();
    send_frame(pl, -1);
    idle(3);
    total++;
    if (qa.size() != 9) begin
      bad++;
      $display("FAIL crc_count got=%0d want=9", qa.size());
    end
    for (int i = 0; i < 9; i++) begin
      exp = {8'(8'h31 + i), (i == 8), (i == 8)};
      total++;
      if (i >= qa.size() || qa[i] !== exp) begin
        bad++;
        $display("FAIL crc_beat%0d got=%h want=%h", i, (i < qa.size()) ? qa[i] : 10'h3FF, exp);
      end
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (sa[k] !== est[k]) begin
        bad++;
        $display("FAIL crc_stat%0d got=%0d want=%0d", k, sa[k], est[k]);
      end
    end
  endtask

  task automatic test_runt;
    logic [7:0] pl[$];
    int         est[5];
    est = '{0, 0, 1, 0, 0};
    pl = '{8'h31, 8'h32, 8'h33, 8'h34};
    clear_mon();
    send_frame(pl, -1);
    idle(3);
    total++;
    if (qa.size() != 0) begin
      bad++;
      $display("FAIL runt_count got=%0d want=0", qa.size());
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (sa[k] !== est[k]) begin
        bad++;
        $display("FAIL runt_stat%0d got=%0d want=%0d", k, sa[k], est[k]);
      end
    end
  endtask

  task automatic test_gmii_err;
    beat_t exp[2];
    int    est[5];
    est = '{0, 0, 0, 1, 0};
    exp = '{{8'h31, 1'b0, 1'b0}, {8'h32, 1'b1, 1'b1}};
    clear_mon();
    send_frame(good_pl, 6);
    idle(3);
    total++;
    if (qa.size() != 2) begin
      bad++;
      $display("FAIL gmii_count got=%0d want=2", qa.size());
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (i >= qa.size() || qa[i] !== exp[i]) begin
        bad++;
        $display("FAIL gmii_beat%0d got=%h want=%h", i, (i < qa.size()) ? qa[i] : 10'h3FF, exp[i]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (sa[k] !== est[k]) begin
        bad++;
        $display("FAIL gmii_stat%0d got=%0d want=%0d", k, sa[k], est[k]);
      end
    end
  endtask

  // Oversize frame on B followed after a single idle cycle by a good frame.
  task automatic test_back_to_back;
    logic [7:0] pl[$];
    beat_t      exp;
    int         est[5];
    est = '{1, 0, 0, 0, 1};
    for (int i = 1; i <= 20; i++) pl.push_back(8'(i));
    clear_mon();
    send_frame(pl, -1);
    send_frame(good_pl, -1);
    idle(3);
    total++;
    if (qb.size() != 21) begin
      bad++;
      $display("FAIL b2b_count_b got=%0d want=21", qb.size());
    end
    for (int i = 0; i < 21; i++) begin
      if (i < 12) exp = {8'(i + 1), (i == 11), (i == 11)};
      else        exp = {8'(8'h31 + i - 12), (i == 20), 1'b0};
      total++;
      if (i >= qb.size() || qb[i] !== exp) begin
        bad++;
        $display("FAIL b2b_beat%0d got=%h want=%h", i, (i < qb.size()) ? qb[i] : 10'h3FF, exp);
      end
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (sb[k] !== est[k]) begin
        bad++;
        $display("FAIL b2b_stat%0d got=%0d want=%0d", k, sb[k], est[k]);
      end
    end
    total++;
    if (qa.size() != 25 || sa[0] != 1 || sa[1] != 1) begin
      bad++;
      $display("FAIL b2b_a got beats=%0d ok=%0d crc=%0d want 25/1/1", qa.size(), sa[0], sa[1]);
    end
  endtask

  task automatic test_reset_mid;
    int est[5];
    est = '{1, 0, 0, 0, 0};
    clear_mon();
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    drive(8'h31, 1'b1, 1'b0);
    drive(8'h32, 1'b1, 1'b0);
    rst = 1'b1;
    drive(8'h33, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 3; i < 13; i++) drive(good_pl[i], 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    idle(3);
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL rstmid_beats got=%0d/%0d want 0/0", qa.size(), qb.size());
    end
    total++;
    if (sa[0] + sa[1] + sa[2] + sa[3] + sa[4] + sb[0] + sb[1] + sb[2] + sb[3] + sb[4] != 0) begin
      bad++;
      $display("FAIL rstmid_stats got ok=%0d runt=%0d gmii=%0d want none", sa[0], sa[2], sa[3]);
    end
    clear_mon();
    send_frame(good_pl, -1);
    idle(3);
    total++;
    if (qa.size() != 9 || qa[qa.size()-1] !== {8'h39, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL rstmid_next_beats got=%0d want=9 ending 39/last", qa.size());
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (sa[k] !== est[k]) begin
        bad++;
        $display("FAIL rstmid_stat%0d got=%0d want=%0d", k, sa[k], est[k]);
      end
    end
  endtask

  initial begin
    good_pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
    test_reset();
    test_good();
    test_crc_err();
    test_runt();
    test_gmii_err();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
